// File: rtl/pc_redirect_ctrl_if.sv
// Redirect request/response bundle between the pipeline
// and the PC redirect controller.
interface pc_redirect_ctrl_if;
  logic        eret_req;
  logic [31:0] epc;
  logic        exc_req;
  logic        exc_refill;
  logic        tlb_refetch_req;
  logic [31:0] refetch_pc;
  logic        br_req;
  logic [31:0] br_target;
  logic        if_busy;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        pc_hold;
  logic        flush_if;
  logic        flush_id;
  logic        flush_ex;

  modport master (
    output eret_req, epc, exc_req, exc_refill,
    output tlb_refetch_req, refetch_pc,
    output br_req, br_target, if_busy,
    input  redir_valid, redir_pc, pc_hold,
    input  flush_if, flush_id, flush_ex
  );

  modport slave (
    input  eret_req, epc, exc_req, exc_refill,
    input  tlb_refetch_req, refetch_pc,
    input  br_req, br_target, if_busy,
    output redir_valid, redir_pc, pc_hold,
    output flush_if, flush_id, flush_ex
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC redirect arbiter: picks the highest-priority redirect,
// holds it while fetch is busy, then issues a one-cycle strobe.
module pc_redirect_ctrl (
  input logic               clk,
  input logic               rst,
  pc_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    ISSUE = 2'd2
  } state_e;

  localparam logic [1:0] C_BR  = 2'd0;
  localparam logic [1:0] C_RF  = 2'd1;
  localparam logic [1:0] C_EXC = 2'd2;
  localparam logic [1:0] C_ER  = 2'd3;

  localparam logic [31:0] V_REFILL = 32'hBFC0_0200;
  localparam logic [31:0] V_GEN    = 32'hBFC0_0380;

  state_e      state_q, state_d;
  logic [1:0]  cls_q, cls_d;
  logic [31:0] tgt_q, tgt_d;
  logic        valid_q;
  logic [31:0] pc_q;
  logic        fif_q, fid_q, fex_q;

  logic [3:0]  hit;
  logic        req_any;
  logic [1:0]  new_cls;
  logic [31:0] new_tgt;
  logic        take;

  assign hit[3] = bus.eret_req;
  assign hit[2] = bus.exc_req & ~bus.eret_req;
  assign hit[1] = bus.tlb_refetch_req
                & ~bus.exc_req & ~bus.eret_req;
  assign hit[0] = bus.br_req & ~bus.tlb_refetch_req
                & ~bus.exc_req & ~bus.eret_req;
  assign req_any = |hit;

  always_comb begin
    new_cls = C_BR;
    new_tgt = '0;
    unique case (1'b1)
      hit[3]: begin
        new_cls = C_ER;
        new_tgt = bus.epc + 32'd4;
      end
      hit[2]: begin
        new_cls = C_EXC;
        new_tgt = bus.exc_refill ? V_REFILL : V_GEN;
      end
      hit[1]: begin
        new_cls = C_RF;
        new_tgt = bus.refetch_pc;
      end
      hit[0]: begin
        new_cls = C_BR;
        new_tgt = bus.br_target;
      end
      default: ;
    endcase
  end

  // Issuing a non-branch makes a same-cycle branch wrong-path.
  always_comb begin
    take = 1'b0;
    unique case (state_q)
      IDLE:    take = req_any;
      PEND:    take = req_any & (new_cls > cls_q);
      ISSUE:   take = req_any & (new_cls >= cls_q);
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    state_d = IDLE;
    cls_d   = cls_q;
    tgt_d   = tgt_q;
    if (take) begin
      cls_d = new_cls;
      tgt_d = new_tgt;
    end
    if (take || state_q == PEND) begin
      state_d = bus.if_busy ? PEND : ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cls_q   <= C_BR;
      tgt_q   <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      fif_q   <= 1'b0;
      fid_q   <= 1'b0;
      fex_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      tgt_q   <= tgt_d;
      valid_q <= (state_d == ISSUE);
      pc_q    <= (state_d == ISSUE) ? tgt_d : '0;
      fif_q   <= (state_d == ISSUE);
      fid_q   <= (state_d == ISSUE) & (cls_d != C_BR);
      fex_q   <= (state_d == ISSUE) & (cls_d != C_BR);
    end
  end

  assign bus.redir_valid = valid_q;
  assign bus.redir_pc    = pc_q;
  assign bus.flush_if    = fif_q;
  assign bus.flush_id    = fid_q;
  assign bus.flush_ex    = fex_q;
  assign bus.pc_hold     = ~rst
                         & ((state_q == PEND)
                         | (take & bus.if_busy));

endmodule
